// File: rtl/ps2_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_digit_entry
//  Purpose  : Turns a stream of PS/2 set-2 scancode bytes into a packed
//             buffer of up to DEPTH BCD digits. Handles make/break and E0
//             prefixes, suppresses typematic repeats, and supports
//             backspace, Esc (clear) and Enter (submit). A held submit
//             level is released by submit_ack.
//  Ports    : CLOCK_50     - clock, rising edge
//             resetn       - synchronous active-low reset
//             sc           - scancode byte, valid when ps2_pressed is high
//             ps2_pressed  - one-cycle byte strobe
//             submit_ack   - consumer has taken the buffer
//             digits       - packed BCD, slot 0 = oldest, unused slots 0
//             count        - number of digits held
//             last_digit   - most recently appended digit
//             digit_valid  - pulse: digit appended
//             overflow     - pulse: digit rejected, buffer full
//             submit       - level from a valid Enter until submit_ack
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_digit_entry #(
    parameter int DEPTH           = 16,
    parameter int ALLOW_KEYPAD    = 1,
    parameter int CLEAR_ON_SUBMIT = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [7:0]                 sc,
    input  logic                       ps2_pressed,
    input  logic                       submit_ack,
    output logic [4*DEPTH-1:0]         digits,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [3:0]                 last_digit,
    output logic                       digit_valid,
    output logic                       overflow,
    output logic                       submit
);

    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_E0   = 2'd1;
    localparam logic [1:0] S_F0   = 2'd2;
    localparam logic [1:0] S_E0F0 = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_make;
    logic               w_brk;
    logic               w_ext;
    logic [8:0]         w_key;
    logic               w_act;
    logic               w_buf_en;
    logic               w_dig_v;
    logic [3:0]         w_dig_val;
    logic [CW-1:0]      w_count_m1;

    logic [8:0]         r_held;
    logic               r_held_v;
    logic [4*DEPTH-1:0] r_digits;
    logic [CW-1:0]      r_count;
    logic [3:0]         r_last;
    logic               r_digit_valid;
    logic               r_overflow;
    logic               r_submit;

    // Prefix state register
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Prefix decode: a byte that is not a prefix completes a make or break
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (ps2_pressed) begin
            case (r_state)
                S_IDLE: begin
                    if (sc == 8'hE0)      w_state_nxt = S_E0;
                    else if (sc == 8'hF0) w_state_nxt = S_F0;
                    else                  w_make      = 1'b1;
                end
                S_E0: begin
                    if (sc == 8'hF0) begin
                        w_state_nxt = S_E0F0;
                    end else begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_F0: begin
                    w_brk       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Digit decode; extended codes (e.g. E0 74, right arrow) are never digits
    always_comb begin
        w_dig_v   = 1'b0;
        w_dig_val = 4'd0;
        if (!w_ext) begin
            w_dig_v = 1'b1;
            case (sc)
                8'h45:   w_dig_val = 4'd0;
                8'h16:   w_dig_val = 4'd1;
                8'h1E:   w_dig_val = 4'd2;
                8'h26:   w_dig_val = 4'd3;
                8'h25:   w_dig_val = 4'd4;
                8'h2E:   w_dig_val = 4'd5;
                8'h36:   w_dig_val = 4'd6;
                8'h3D:   w_dig_val = 4'd7;
                8'h3E:   w_dig_val = 4'd8;
                8'h46:   w_dig_val = 4'd9;
                default: w_dig_v   = 1'b0;
            endcase
            if (!w_dig_v && ALLOW_KEYPAD != 0) begin
                w_dig_v = 1'b1;
                case (sc)
                    8'h70:   w_dig_val = 4'd0;
                    8'h69:   w_dig_val = 4'd1;
                    8'h72:   w_dig_val = 4'd2;
                    8'h7A:   w_dig_val = 4'd3;
                    8'h6B:   w_dig_val = 4'd4;
                    8'h73:   w_dig_val = 4'd5;
                    8'h74:   w_dig_val = 4'd6;
                    8'h6C:   w_dig_val = 4'd7;
                    8'h75:   w_dig_val = 4'd8;
                    8'h7D:   w_dig_val = 4'd9;
                    default: w_dig_v   = 1'b0;
                endcase
            end
        end
    end

    assign w_key      = {w_ext, sc};
    // A make matching the still-held key is typematic repeat: ignored entirely
    assign w_act      = w_make && !(r_held_v && (r_held == w_key));
    // Buffer actions use the pre-ack submit level, so a byte arriving with
    // submit_ack is dropped
    assign w_buf_en   = w_act && !r_submit;
    assign w_count_m1 = r_count - 1'b1;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_held        <= '0;
            r_held_v      <= 1'b0;
            r_digits      <= '0;
            r_count       <= '0;
            r_last        <= '0;
            r_digit_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_submit      <= 1'b0;
        end else begin
            r_digit_valid <= 1'b0;
            r_overflow    <= 1'b0;

            if (w_act) begin
                r_held   <= w_key;
                r_held_v <= 1'b1;
            end else if (w_brk && r_held_v && (r_held == w_key)) begin
                r_held_v <= 1'b0;
            end

            if (submit_ack && r_submit) begin
                r_submit <= 1'b0;
                if (CLEAR_ON_SUBMIT != 0) begin
                    r_digits <= '0;
                    r_count  <= '0;
                end
            end else if (w_buf_en) begin
                if (w_dig_v) begin
                    if (r_count != CW'(DEPTH)) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (r_count == CW'(i)) r_digits[4*i +: 4] <= w_dig_val;
                        end
                        r_count       <= r_count + 1'b1;
                        r_last        <= w_dig_val;
                        r_digit_valid <= 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    case (sc)
                        8'h66: begin
                            if (r_count != '0) begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    if (w_count_m1 == CW'(i)) r_digits[4*i +: 4] <= 4'd0;
                                end
                                r_count <= w_count_m1;
                            end
                        end
                        8'h76: begin
                            r_digits <= '0;
                            r_count  <= '0;
                        end
                        8'h5A: begin
                            if (r_count != '0) r_submit <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign digits      = r_digits;
    assign count       = r_count;
    assign last_digit  = r_last;
    assign digit_valid = r_digit_valid;
    assign overflow    = r_overflow;
    assign submit      = r_submit;

endmodule
`default_nettype wire

// File: tb/tb_ps2_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_digit_entry
//  Purpose  : Two instances of ps2_digit_entry (DEPTH 16 / keypad / clear on
//             submit, and DEPTH 4 / no keypad / retain on submit) driven by
//             one byte stream. A behavioural keyboard model predicts each
//             cycle's outputs into a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_digit_entry;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  sc = 8'h00;
    logic        ps2_pressed = 1'b0;
    logic        submit_ack = 1'b0;

    logic [63:0] d0_digits;
    logic [4:0]  d0_count;
    logic [3:0]  d0_last;
    logic        d0_dv, d0_ov, d0_sub;
    logic [15:0] d1_digits;
    logic [2:0]  d1_count;
    logic [3:0]  d1_last;
    logic        d1_dv, d1_ov, d1_sub;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_digit_entry #(.DEPTH(16), .ALLOW_KEYPAD(1), .CLEAR_ON_SUBMIT(1)) u_dut0 (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .sc(sc), .ps2_pressed(ps2_pressed),
        .submit_ack(submit_ack), .digits(d0_digits), .count(d0_count),
        .last_digit(d0_last), .digit_valid(d0_dv), .overflow(d0_ov), .submit(d0_sub)
    );

    ps2_digit_entry #(.DEPTH(4), .ALLOW_KEYPAD(0), .CLEAR_ON_SUBMIT(0)) u_dut1 (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .sc(sc), .ps2_pressed(ps2_pressed),
        .submit_ack(submit_ack), .digits(d1_digits), .count(d1_count),
        .last_digit(d1_last), .digit_valid(d1_dv), .overflow(d1_ov), .submit(d1_sub)
    );

    typedef struct {
        logic [63:0] dig;
        logic [7:0]  cnt;
        logic [3:0]  last;
        logic        dv;
        logic        ov;
        logic        sub;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state, one entry per instance
    int         cfg_depth[2] = '{16, 4};
    int         cfg_kp[2]    = '{1, 0};
    int         cfg_clr[2]   = '{1, 0};
    int         m_cnt[2];
    int         m_buf[2][16];
    int         m_last[2];
    bit         m_e0[2], m_f0[2], m_hv[2], m_sub[2];
    logic [8:0] m_held[2];

    logic [7:0] main_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] kp_codes[10]   = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dig_of(input logic [7:0] b, input bit ext, input int kp);
        int r;
        r = -1;
        if (!ext) begin
            for (int i = 0; i < 10; i++) begin
                if (main_codes[i] == b) r = i;
                if (kp != 0 && kp_codes[i] == b) r = i;
            end
        end
        return r;
    endfunction

    task automatic model_step(input int k, input bit p, input logic [7:0] b,
                              input bit a, input bit rn, output exp_t e);
        bit         presub, ext, brk;
        logic [8:0] key;
        int         d;
        e.dv = 1'b0;
        e.ov = 1'b0;
        if (!rn) begin
            m_cnt[k] = 0; m_last[k] = 0; m_e0[k] = 0; m_f0[k] = 0;
            m_hv[k] = 0; m_sub[k] = 0; m_held[k] = '0;
        end else begin
            presub = m_sub[k];
            if (a && m_sub[k]) begin
                m_sub[k] = 0;
                if (cfg_clr[k] != 0) m_cnt[k] = 0;
            end
            if (p) begin
                if (b == 8'hE0 && !m_e0[k] && !m_f0[k]) begin
                    m_e0[k] = 1;
                end else if (b == 8'hF0 && !m_f0[k]) begin
                    m_f0[k] = 1;
                end else begin
                    ext = m_e0[k];
                    brk = m_f0[k];
                    m_e0[k] = 0;
                    m_f0[k] = 0;
                    key = {ext, b};
                    if (brk) begin
                        if (m_hv[k] && m_held[k] == key) m_hv[k] = 0;
                    end else if (!(m_hv[k] && m_held[k] == key)) begin
                        m_held[k] = key;
                        m_hv[k] = 1;
                        if (!presub) begin
                            d = dig_of(b, ext, cfg_kp[k]);
                            if (d >= 0) begin
                                if (m_cnt[k] < cfg_depth[k]) begin
                                    m_buf[k][m_cnt[k]] = d;
                                    m_cnt[k]++;
                                    m_last[k] = d;
                                    e.dv = 1'b1;
                                end else begin
                                    e.ov = 1'b1;
                                end
                            end else if (b == 8'h66) begin
                                if (m_cnt[k] > 0) m_cnt[k]--;
                            end else if (b == 8'h76) begin
                                m_cnt[k] = 0;
                            end else if (b == 8'h5A) begin
                                if (m_cnt[k] > 0) m_sub[k] = 1;
                            end
                        end
                    end
                end
            end
        end
        e.dig = '0;
        for (int i = 0; i < m_cnt[k]; i++) e.dig[4*i +: 4] = m_buf[k][i][3:0];
        e.cnt  = 8'(m_cnt[k]);
        e.last = 4'(m_last[k]);
        e.sub  = m_sub[k];
    endtask

    // One clock: drive inputs, predict, let the edge happen, compare 1 ns later
    task automatic cycle(input bit p, input logic [7:0] b, input bit a, input bit rn);
        exp_t e;
        ps2_pressed = p;
        sc          = b;
        submit_ack  = a;
        resetn      = rn;
        for (int k = 0; k < 2; k++) begin
            model_step(k, p, b, a, rn, e);
            sb.push_back(e);
        end
        @(posedge CLOCK_50);
        #1;
        e = sb.pop_front();
        check("c0.digits", d0_digits, e.dig);
        check("c0.count", {59'd0, d0_count}, {56'd0, e.cnt});
        check("c0.last", {60'd0, d0_last}, {60'd0, e.last});
        check("c0.digit_valid", {63'd0, d0_dv}, {63'd0, e.dv});
        check("c0.overflow", {63'd0, d0_ov}, {63'd0, e.ov});
        check("c0.submit", {63'd0, d0_sub}, {63'd0, e.sub});
        e = sb.pop_front();
        check("c1.digits", {48'd0, d1_digits}, e.dig);
        check("c1.count", {61'd0, d1_count}, {56'd0, e.cnt});
        check("c1.last", {60'd0, d1_last}, {60'd0, e.last});
        check("c1.digit_valid", {63'd0, d1_dv}, {63'd0, e.dv});
        check("c1.overflow", {63'd0, d1_ov}, {63'd0, e.ov});
        check("c1.submit", {63'd0, d1_sub}, {63'd0, e.sub});
    endtask

    task automatic press(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic tap(input logic [7:0] b);
        press(b); idle(); press(8'hF0); press(b); idle();
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        idle();
    endtask

    logic [7:0] pool[12] = '{8'h16, 8'h1E, 8'h45, 8'h3D, 8'h74, 8'h70,
                             8'h66, 8'h76, 8'h5A, 8'hE0, 8'hF0, 8'h12};

    initial begin
        // Reset state, then 1, 2, Enter, ack
        do_reset();
        tap(8'h16); tap(8'h1E); tap(8'h5A);
        idle();
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle();

        // Typematic repeat of key 7
        do_reset();
        press(8'h3D); press(8'h3D); press(8'h3D);
        press(8'hF0); press(8'h3D);
        press(8'h3D); press(8'hF0); press(8'h3D);
        idle();

        // Keypad 6 versus right arrow
        do_reset();
        tap(8'h74);
        press(8'hE0); press(8'h74); press(8'hE0); press(8'hF0); press(8'h74);
        idle();

        // Fill past capacity, then backspace
        do_reset();
        tap(8'h16); tap(8'h1E); tap(8'h26); tap(8'h25); tap(8'h2E);
        tap(8'h66);
        tap(8'h66);

        // Enter on empty, then submit gating, ack with a coincident byte
        do_reset();
        tap(8'h5A);
        tap(8'h26); tap(8'h25); tap(8'h2E);
        tap(8'h5A);
        tap(8'h2E);
        tap(8'h76);
        cycle(1'b1, 8'h16, 1'b1, 1'b1);
        idle();
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        press(8'hF0); press(8'h16);
        tap(8'h3E);

        // Reset after an E0 discards the prefix
        do_reset();
        press(8'hE0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        press(8'h5A); press(8'hF0); press(8'h5A);
        tap(8'h16);

        // Random mix
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) < 7), pool[$urandom_range(0, 11)],
                  ($urandom_range(0, 9) == 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_digit_entry.md
# ps2_digit_entry

Parametrised successor to the single-digit PS/2 converter. Decodes a stream of PS/2 set-2 scancode bytes into a buffer of up to DEPTH BCD digits, with these features:
- make/break and extended-prefix tracking
- typematic-repeat suppression
- backspace, clear and Enter handling
- a submit/acknowledge handshake

It sits between the PS/2 receiver and the Luhn checker. It replaces the one-hot number, shift and check strobes with a packed digit buffer and a level-held submit.

## Interface
Parameters:
- DEPTH, 16, maximum digits held (≥2).
- ALLOW_KEYPAD, 1, when 1 numeric-keypad digit codes are accepted as digits.
- CLEAR_ON_SUBMIT, 1, when 1 the buffer empties on submit_ack; when 0 the buffer is retained.

Ports:
- CLOCK_50 in 1: the single clock. All logic is on its rising edge.
- resetn in 1: reset, synchronous and active-low.
- sc in 8: scancode byte from the PS/2 receiver.
- ps2_pressed in 1: one-cycle strobe marking sc valid.
- submit_ack in 1: consumer has taken the buffer.
- digits out 4*DEPTH: packed BCD. Slot i is [4i+3:4i]; slot 0 is the oldest digit. Slots ≥ count read 0.
- count out $clog2(DEPTH+1): number of digits held.
- last_digit out 4: value of the most recently accepted digit.
- digit_valid out 1: one-cycle pulse when a digit is appended.
- overflow out 1: one-cycle pulse when a digit is rejected because the buffer is full.
- submit out 1: level. High from a valid Enter until submit_ack.

## Operation
Prefix FSM (states IDLE, E0, F0, E0F0), advanced only on ps2_pressed:
- IDLE: byte E0 → E0; byte F0 → F0; any other byte is a make code (ext=0) → IDLE.
- E0: F0 → E0F0; any other byte is a make code (ext=1) → IDLE.
- F0: any byte is a break code (ext=0) → IDLE.
- E0F0: any byte is a break code (ext=1) → IDLE.

Held-key tracking:
- 9-bit register held = {ext, code} plus a held_v flag.
- Make code equal to held while held_v=1 is a typematic repeat and is ignored entirely.
- Any other make code sets held to the new key and is acted on.
- Break code matching held clears held_v. A non-matching break has no effect.

Make-code actions:
- Main-row digits (ext=0): 45,16,1E,26,25,2E,36,3D,3E,46 → 0..9.
- Keypad digits (ext=0, only when ALLOW_KEYPAD=1): 70,69,72,7A,6B,73,74,6C,75,7D → 0..9. E0 74 (right arrow) is never a digit.
- Digit, count<DEPTH: write to slot count, count+1, last_digit updated, digit_valid pulses.
- Digit, count==DEPTH: buffer unchanged, overflow pulses.
- 66 (backspace): if count>0, clear slot count-1 and decrement count. At count 0 it is a no-op.
- 76 (Esc): clear all slots, count=0.
- 5A, either ext value: if count>0, set submit=1. At count 0 it is ignored.
- All other codes are ignored.

Submit behaviour:
- While submit=1, all buffer actions (digit, backspace, Esc, Enter) are ignored. The prefix FSM and held tracking continue to update.
- submit_ack while submit=1: clear submit. If CLEAR_ON_SUBMIT=1, also clear slots and set count=0.
- submit_ack while submit=0 is ignored.

## Timing
- All outputs are registered.
- Reset values: digits=0, count=0, last_digit=0, digit_valid=0, overflow=0, submit=0, FSM=IDLE, held_v=0.
- Reset mid-sequence (e.g. after E0 or F0) discards the partial prefix.
- Latency: the completing byte is strobed in cycle N. digits, count, last_digit and submit reflect it, and digit_valid or overflow pulse, in cycle N+1.
- Pulses last exactly one cycle, even if ps2_pressed is held high. Each high cycle of ps2_pressed is treated as a new byte.
- submit_ack sampled in cycle N: submit drops, and the buffer clears if configured, in cycle N+1.
- ps2_pressed and submit_ack in the same cycle: the byte is evaluated against the pre-ack state (submit=1), so any buffer action it carries is dropped. Its FSM and held updates still apply.
- Backspace and digit events never coincide, because bytes are serialised.

## Test plan
- Reset, then key 1 (16, F0 16), 2 (1E, F0 1E), Enter (5A, F0 5A) → count=2, digits[7:0]=8'h21, submit=1. Then submit_ack → count=0, digits=0, submit=0.
- Key 7 as 3D, 3D, 3D (typematic), F0 3D, then 3D, F0 3D → exactly two digit_valid pulses, count=2, both slots 7.
- ALLOW_KEYPAD=1: 74 → digit 6 appended. E0 74, E0 F0 74 → no change. With ALLOW_KEYPAD=0, 74 → ignored.
- DEPTH=4: enter five digits → count=4, one overflow pulse, slot 3 holds the 4th digit. Backspace (66) → count=3, slot 3 reads 0.
- Enter at count 0 → submit stays 0. Then 3 digits, Enter, then digit 5 while submit=1 → count stays 3. Esc while submit=1 → ignored.
- Byte E0 then resetn low for one cycle, then 5A → treated as non-extended Enter. Count 0, so no submit. FSM in IDLE.
